// File: rtl/a2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : a2s_pkg                                                |
// | Description : Shared constants and FSM encoding for the AXI-to-      |
// |               stream ring reader.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package a2s_pkg;

  // One burst is one 64-byte block of 16 x 32-bit beats.
  localparam int BURST_BEATS = 16;
  localparam int BEAT_W      = $clog2(BURST_BEATS);
  // Ping-pong buffer address: {half, beat}.
  localparam int ADDR_W      = BEAT_W + 1;
  localparam logic [3:0] ARLEN = 4'(BURST_BEATS - 1);

  // DDR address split: 6-bit byte offset inside a block, 18-bit block index.
  localparam int BLK_OFF_W  = 6;
  localparam int BLK_IDX_W  = 18;
  localparam int BLK_BASE_W = 32 - BLK_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } a2s_state_e;

endpackage
`default_nettype wire

// File: rtl/a2s_axi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : a2s_axi_if                                             |
// | Description : AXI3 read-address / read-data channel subset used by   |
// |               the ring reader (rdata bypasses the controller).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface a2s_axi_if;
  logic [31:0] AXI_araddr;
  logic        AXI_arvalid;
  logic        AXI_arready;
  logic [3:0]  AXI_arlen;
  logic        AXI_rvalid;
  logic        AXI_rready;
  logic        AXI_rlast;
  logic [1:0]  AXI_rresp;

  modport master (
    output AXI_araddr, AXI_arvalid, AXI_arlen, AXI_rready,
    input  AXI_arready, AXI_rvalid, AXI_rlast, AXI_rresp
  );

  modport slave (
    input  AXI_araddr, AXI_arvalid, AXI_arlen, AXI_rready,
    output AXI_arready, AXI_rvalid, AXI_rlast, AXI_rresp
  );
endinterface
`default_nettype wire

// File: rtl/a2s_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : a2s_ring_ptr                                           |
// | Description : Block index into a ring of `size` blocks plus a count  |
// |               of completed wraps.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module a2s_ring_ptr
  import a2s_pkg::*;
#(
  parameter int IDX_W = BLK_IDX_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [IDX_W-1:0] size,
  output logic [IDX_W-1:0] blk,
  output logic [CNT_W-1:0] wraps
);

  logic [IDX_W-1:0] r_blk;
  logic [CNT_W-1:0] r_wraps;
  logic             w_at_end;

  assign w_at_end = (r_blk == size - IDX_W'(1));

  // Advance the block index; the last block of the ring folds back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk   <= '0;
      r_wraps <= '0;
    end else if (clr) begin
      r_blk   <= '0;
      r_wraps <= '0;
    end else if (adv) begin
      if (w_at_end) begin
        r_blk   <= '0;
        r_wraps <= r_wraps + CNT_W'(1);
      end else begin
        r_blk   <= r_blk + IDX_W'(1);
      end
    end
  end

  assign blk   = r_blk;
  assign wraps = r_wraps;

endmodule
`default_nettype wire

// File: rtl/a2s_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : a2s_controller                                         |
// | Description : Fetches a DDR ring buffer in 16-beat AXI3 bursts into  |
// |               a two-half ping-pong buffer and hands words to a       |
// |               same-clock stream consumer.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module a2s_controller
  import a2s_pkg::*;
(
  input  logic              AXI_clk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic              Oen,
  output logic [ADDR_W-1:0] Oaddr,
  output logic              Ovalid,
  input  logic [31:0]       obase,
  input  logic [23:6]       osize,
  output logic [23:6]       oacnt,
  output logic [31:0]       obcnt,
  output logic              underrun,
  output logic              rerr,
  a2s_axi_if.master         axi,
  output logic [ADDR_W-1:0] a2s_addr,
  output logic              a2s_en
);

  a2s_state_e            r_state;
  a2s_state_e            w_state_nxt;
  logic [1:0]            r_hv;
  logic [1:0]            w_hv_set;
  logic [1:0]            w_hv_clr;
  logic                  r_fh;
  logic                  r_rh;
  logic [BEAT_W-1:0]     r_beat;
  logic [BEAT_W-1:0]     r_rcnt;
  logic                  r_drop;
  logic [31:0]           r_araddr;
  logic                  r_underrun;
  logic                  r_rerr;
  logic [BLK_IDX_W-1:0]  w_fblk;
  logic [BLK_BASE_W-1:0] w_blk_base;
  logic                  w_ar_load;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_r_hs;
  logic                  w_last_hs;
  logic                  w_fill;
  logic                  w_rd;
  logic                  w_release;
  logic [31:0]           w_fetch_wraps_unused;
  logic [BLK_OFF_W-1:0]  w_obase_lsb_unused;

  assign w_obase_lsb_unused = obase[BLK_OFF_W-1:0];
  assign w_blk_base = obase[31:BLK_OFF_W] + BLK_BASE_W'(w_fblk);

  assign w_r_hs    = w_rready & axi.AXI_rvalid;
  assign w_last_hs = w_r_hs & axi.AXI_rlast;
  // A burst cut short by sync must not mark its half valid.
  assign w_fill    = w_last_hs & ~r_drop & ~sync;
  assign w_rd      = Oen & Ovalid & ~sync;
  assign w_release = w_rd & (r_rcnt == BEAT_W'(BURST_BEATS - 1));

  // Fetch FSM state register.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fetch FSM next state and AXI handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_ar_load   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_hv[r_fh] && !sync) begin
          w_state_nxt = ST_AR;
          w_ar_load   = 1'b1;
        end
      end
      ST_AR: begin
        w_arvalid = 1'b1;
        if (axi.AXI_arready) w_state_nxt = ST_R;
      end
      ST_R: begin
        w_rready = 1'b1;
        if (axi.AXI_rvalid && axi.AXI_rlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst address, beat counter and the drop flag for sync-aborted bursts.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_araddr <= '0;
      r_beat   <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_ar_load) r_araddr <= {w_blk_base, BLK_OFF_W'(0)};
      if (r_state == ST_AR && axi.AXI_arready) r_beat <= '0;
      else if (w_r_hs)                         r_beat <= r_beat + BEAT_W'(1);
      if (w_last_hs)
        r_drop <= 1'b0;
      else if (sync && (r_state == ST_AR || r_state == ST_R))
        r_drop <= 1'b1;
    end
  end

  // Sticky error flags, cleared by sync.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rerr     <= 1'b0;
      r_underrun <= 1'b0;
    end else if (sync) begin
      r_rerr     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_r_hs && axi.AXI_rresp != 2'b00) r_rerr     <= 1'b1;
      if (Oen && !Ovalid)                   r_underrun <= 1'b1;
    end
  end

  // Fill and release always target different halves, so both may apply.
  always_comb begin
    w_hv_set = 2'b00;
    w_hv_clr = 2'b00;
    if (w_fill)    w_hv_set[r_fh] = 1'b1;
    if (w_release) w_hv_clr[r_rh] = 1'b1;
  end

  // Half-valid flags, fill/read half selectors and consumer word counter.
  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv   <= 2'b00;
      r_fh   <= 1'b0;
      r_rh   <= 1'b0;
      r_rcnt <= '0;
    end else if (sync) begin
      r_hv   <= 2'b00;
      r_fh   <= 1'b0;
      r_rh   <= 1'b0;
      r_rcnt <= '0;
    end else begin
      r_hv <= (r_hv | w_hv_set) & ~w_hv_clr;
      if (w_fill)    r_fh   <= ~r_fh;
      if (w_release) r_rh   <= ~r_rh;
      if (w_rd)      r_rcnt <= r_rcnt + BEAT_W'(1);
    end
  end

  a2s_ring_ptr #(
    .IDX_W (BLK_IDX_W),
    .CNT_W (32)
  ) u_fetch_ptr (
    .clk   (AXI_clk),
    .rst_n (rst_n),
    .clr   (sync),
    .adv   (w_fill),
    .size  (osize),
    .blk   (w_fblk),
    .wraps (w_fetch_wraps_unused)
  );

  a2s_ring_ptr #(
    .IDX_W (BLK_IDX_W),
    .CNT_W (32)
  ) u_read_ptr (
    .clk   (AXI_clk),
    .rst_n (rst_n),
    .clr   (sync),
    .adv   (w_release),
    .size  (osize),
    .blk   (oacnt),
    .wraps (obcnt)
  );

  assign axi.AXI_araddr  = r_araddr;
  assign axi.AXI_arvalid = w_arvalid;
  assign axi.AXI_arlen   = ARLEN;
  assign axi.AXI_rready  = w_rready;

  assign a2s_addr = {r_fh, r_beat};
  assign a2s_en   = w_r_hs & ~r_drop;
  assign Ovalid   = r_hv[r_rh];
  assign Oaddr    = {r_rh, r_rcnt};
  assign underrun = r_underrun;
  assign rerr     = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_a2s_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_a2s_controller                                      |
// | Description : Directed self-checking bench for a2s_controller with a |
// |               behavioural AXI read slave and stream consumer.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_a2s_controller;

  logic        clk;
  logic        rst_n;
  logic        sync;
  logic        Oen;
  logic [4:0]  Oaddr;
  logic        Ovalid;
  logic [31:0] obase;
  logic [17:0] osize;
  logic [17:0] oacnt;
  logic [31:0] obcnt;
  logic        underrun;
  logic        rerr;
  logic [4:0]  a2s_addr;
  logic        a2s_en;

  a2s_axi_if axi();

  a2s_controller dut (
    .AXI_clk  (clk),
    .rst_n    (rst_n),
    .sync     (sync),
    .Oen      (Oen),
    .Oaddr    (Oaddr),
    .Ovalid   (Ovalid),
    .obase    (obase),
    .osize    (osize),
    .oacnt    (oacnt),
    .obcnt    (obcnt),
    .underrun (underrun),
    .rerr     (rerr),
    .axi      (axi),
    .a2s_addr (a2s_addr),
    .a2s_en   (a2s_en)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Slave configuration.
  int ar_lat   = 0;
  int err_beat = -1;

  // Monitor logs.
  logic [31:0] ar_q[$];
  logic [4:0]  wq[$];
  bit          eq[$];
  int          arv_cycles = 0;
  int          ar_viol    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Main-sequence step: just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_logs();
    ar_q.delete();
    wq.delete();
    eq.delete();
    arv_cycles = 0;
  endtask

  // Consumer that only strobes Oen on valid words; checks read addresses.
  task automatic consume(input int n, input int k0);
    int got;
    int guard;
    int bad;
    logic [4:0] e;
    got = 0; guard = 0; bad = 0;
    while (got < n && guard < 3000) begin
      tick();
      guard++;
      if (Ovalid) begin
        Oen = 1'b1;
        e = 5'((k0 + got) % 32);
        if (Oaddr !== e) bad++;
        got++;
      end else begin
        Oen = 1'b0;
      end
    end
    tick();
    Oen = 1'b0;
    chk("consume_count", got, n);
    chk("oaddr_sequence_errors", bad, 0);
  endtask

  // AXI read slave: arready after ar_lat cycles, then 16 back-to-back beats.
  initial begin
    axi.AXI_arready = 1'b0;
    axi.AXI_rvalid  = 1'b0;
    axi.AXI_rlast   = 1'b0;
    axi.AXI_rresp   = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (axi.AXI_arvalid) begin
        repeat (ar_lat) begin @(posedge clk); #1; end
        axi.AXI_arready = 1'b1;
        @(posedge clk); #1;
        axi.AXI_arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
          axi.AXI_rvalid = 1'b1;
          axi.AXI_rlast  = (b == 15);
          axi.AXI_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          @(posedge clk); #1;
        end
        axi.AXI_rvalid = 1'b0;
        axi.AXI_rlast  = 1'b0;
        axi.AXI_rresp  = 2'b00;
      end
    end
  end

  // Monitor: AR handshakes, R handshakes, AR stability while stalled.
  initial begin
    logic        p_arv;
    logic        p_arr;
    logic [31:0] p_ara;
    p_arv = 1'b0; p_arr = 1'b0; p_ara = '0;
    forever begin
      @(negedge clk);
      if (axi.AXI_arvalid && axi.AXI_arready) ar_q.push_back(axi.AXI_araddr);
      if (axi.AXI_arvalid) arv_cycles++;
      if (axi.AXI_rvalid && axi.AXI_rready) begin
        wq.push_back(a2s_addr);
        eq.push_back(a2s_en);
      end
      if (p_arv && !p_arr && (!axi.AXI_arvalid || axi.AXI_araddr !== p_ara)) ar_viol++;
      p_arv = axi.AXI_arvalid;
      p_arr = axi.AXI_arready;
      p_ara = axi.AXI_araddr;
    end
  end

  initial begin
    int lat;
    int bad;
    int ones;
    int guard;

    rst_n = 1'b0; sync = 1'b0; Oen = 1'b0;
    obase = 32'h1000_0000; osize = 18'd4;

    // Reset state.
    repeat (3) tick();
    chk("rst_arvalid",  axi.AXI_arvalid, 0);
    chk("rst_rready",   axi.AXI_rready, 0);
    chk("rst_a2s_en",   a2s_en, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_rerr",     rerr, 0);
    chk("rst_oaddr",    Oaddr, 0);
    chk("rst_ovalid",   Ovalid, 0);
    chk("rst_oacnt",    oacnt, 0);
    chk("rst_obcnt",    obcnt, 0);
    chk("rst_araddr",   axi.AXI_araddr, 0);
    chk("arlen",        axi.AXI_arlen, 4'hf);

    // First two bursts after sync; no third until a half is freed.
    rst_n = 1'b1; sync = 1'b1;
    clr_logs();
    tick();
    sync = 1'b0;
    lat = 0;
    while (!Ovalid && lat < 200) begin tick(); lat++; end
    chk("first_ovalid_latency", lat, 18);
    chk("writes_at_first_ovalid", wq.size(), 16);
    repeat (60) tick();
    chk("fill_write_count", wq.size(), 32);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== 5'(i) || !eq[i]) bad++;
    chk("fill_write_addr_errors", bad, 0);
    chk("fill_ar_count", ar_q.size(), 2);
    chk("fill_ar0", ar_q[0], 32'h1000_0000);
    chk("fill_ar1", ar_q[1], 32'h1000_0040);
    chk("fill_idle_arvalid", axi.AXI_arvalid, 0);
    chk("fill_ovalid", Ovalid, 1);

    // Steady streaming through three ring passes.
    consume(128, 0);
    chk("obcnt_after_128", obcnt, 2);
    chk("oacnt_after_128", oacnt, 0);
    consume(64, 128);
    chk("obcnt_after_192", obcnt, 3);
    chk("oacnt_after_192", oacnt, 0);
    chk("stream_underrun", underrun, 0);
    chk("stream_ar_enough", ar_q.size() >= 12, 1);
    chk("stream_ar3", ar_q[3], 32'h1000_00C0);
    chk("stream_ar4", ar_q[4], 32'h1000_0000);
    bad = 0;
    foreach (ar_q[i]) if (ar_q[i] !== 32'h1000_0000 + 32'((i % 4) * 64)) bad++;
    chk("stream_ar_seq_errors", bad, 0);

    // Oen held across sync with a slow AR channel.
    repeat (60) tick();
    ar_lat = 10;
    clr_logs();
    Oen = 1'b1; sync = 1'b1;
    tick();
    chk("sync_prio_oaddr", Oaddr, 0);
    chk("sync_clr_ovalid", Ovalid, 0);
    chk("sync_clr_obcnt", obcnt, 0);
    sync = 1'b0;
    lat = 0; bad = 0;
    while (lat < 200) begin
      tick(); lat++;
      if (lat == 1) chk("underrun_set", underrun, 1);
      if (Ovalid) break;
      if (Oaddr !== 5'd0) bad++;
    end
    Oen = 1'b0;
    chk("underrun_ovalid_latency", lat, 28);
    chk("underrun_oaddr_moved", bad, 0);
    chk("underrun_oaddr_at_valid", Oaddr, 0);
    chk("underrun_ar0", ar_q[0], 32'h1000_0000);

    // sync during beat 7 of a burst; low obase bits must be ignored.
    repeat (60) tick();
    ar_lat = 0;
    obase = 32'h2345_67A5;
    clr_logs();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    guard = 0;
    while (!(axi.AXI_rvalid && axi.AXI_rready && a2s_addr == 5'd7) && guard < 200) begin
      tick(); guard++;
    end
    chk("beat7_reached", guard < 200, 1);
    sync = 1'b1;
    ar_q.delete();
    tick();
    sync = 1'b0;
    guard = 0;
    while (ar_q.size() == 0 && guard < 200) begin tick(); guard++; end
    chk("drop_beats_logged", wq.size(), 16);
    bad = 0; ones = 0;
    foreach (eq[i]) begin
      if (eq[i] !== (i < 8)) bad++;
      if (eq[i]) ones++;
    end
    chk("drop_en_pattern_errors", bad, 0);
    chk("drop_en_count", ones, 8);
    chk("drop_next_ar", ar_q[0], 32'h2345_6780);
    chk("drop_hv_empty", Ovalid, 0);

    // rresp error on beat 5 of an otherwise normal burst.
    repeat (60) tick();
    chk("rerr_before", rerr, 0);
    err_beat = 5;
    clr_logs();
    consume(16, 0);
    guard = 0;
    while (wq.size() < 16 && guard < 200) begin tick(); guard++; end
    repeat (2) tick();
    err_beat = -1;
    chk("rerr_after", rerr, 1);
    chk("rerr_ar", ar_q[0], 32'h2345_6800);
    bad = 0;
    foreach (wq[i]) if (wq[i] !== 5'(i) || !eq[i]) bad++;
    chk("rerr_write_errors", bad, 0);
    chk("rerr_write_count", wq.size(), 16);
    chk("rerr_ovalid", Ovalid, 1);

    // AR held off for 20 cycles.
    ar_lat = 20;
    clr_logs();
    consume(16, 16);
    guard = 0;
    while (ar_q.size() == 0 && guard < 300) begin tick(); guard++; end
    chk("stall_ar_addr", ar_q[0], 32'h2345_6840);
    chk("stall_arvalid_cycles", arv_cycles, 21);
    repeat (40) tick();
    chk("stall_handshakes", ar_q.size(), 1);
    chk("ar_stability_violations", ar_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0x1 expected 0x0");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/a2s_controller.md
Name: a2s_controller

Overview:
- AXI3 read-master counterpart of the stream-to-AXI writer: fetches a DDR ring buffer (obase, osize 64-byte blocks) in 16-beat x 32-bit bursts.
- Each burst is written into an external 32-entry ping-pong buffer (two 16-word halves).
- Exposes a read pointer to a same-clock stream consumer.
- Sits between the HP AXI port and the TX stream path.

Parameters:
- BURST_BEATS, 16, beats per burst; fixed, one 64-byte block.
- ADDR_W, 5, ping-pong buffer address width.

Ports:
- AXI_clk  in  1  sole clock (AXI and stream side).
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  synchronous restart: pointers to block 0, buffer emptied.
- Oen  in  1  consumer read strobe, one word per cycle.
- Oaddr  out  5  buffer read address {rh, rcnt[3:0]}.
- Ovalid  out  1  word at Oaddr is valid (current read half filled).
- obase  in  32  ring base address; bits [5:0] ignored.
- osize  in  18 [23:6]  ring size in 64-byte blocks; must be >= 1.
- oacnt  out  18 [23:6]  block index being consumed.
- obcnt  out  32  completed consumer ring wraps.
- underrun  out  1  sticky: Oen seen while Ovalid=0.
- rerr  out  1  sticky: any R beat with AXI_rresp != 0.
- AXI_araddr  out  32  burst address.
- AXI_arvalid  out  1  AR valid.
- AXI_arready  in  1  AR ready.
- AXI_arlen  out  4  constant 4'hf.
- AXI_rdata is not routed here; it goes straight to the buffer write data.
- AXI_rvalid  in  1  R valid.
- AXI_rready  out  1  R ready.
- AXI_rlast  in  1  R last.
- AXI_rresp  in  2  R response.
- a2s_addr  out  5  buffer write address {fh, beat}.
- a2s_en  out  1  buffer write enable; equals AXI_rvalid & AXI_rready & ~drop.

Behaviour:
- Reset (rst_n=0, async) clears all of the following:
  - Outputs: arvalid, rready, a2s_en, underrun, rerr all 0; Oaddr 0, oacnt 0, obcnt 0, araddr 0.
  - Internal state: hv[1:0]=00, fh=0, rh=0, fblk=0, drop=0; state IDLE.
- Fetch FSM states: IDLE, AR, R.
- IDLE -> AR when hv[fh]==0 and sync==0.
  - araddr latched as {obase[31:6]+fblk, 6'b0}; arvalid=1 on the next cycle.
- AR: hold arvalid and araddr until arready. On handshake: arvalid=0, beat=0, -> R.
- R: rready=1. On each rvalid&rready:
  - a2s_en=1 combinationally (unless drop), a2s_addr={fh,beat}; beat increments.
  - rresp!=0 sets rerr.
- On the rlast handshake:
  - If drop=0: hv[fh]<=1, fh toggles, fblk advances (fblk==osize-1 wraps to 0).
  - If drop=1: drop<=0 and no state update.
  - Then -> IDLE; rready=0 the following cycle.
- rlast is trusted. If rlast does not arrive on beat 15, beat wraps; this is not checked.
- Consumer side:
  - Ovalid = hv[rh].
  - Oen & Ovalid: rcnt[3:0] increments.
  - At rcnt[3:0]==f: hv[rh] clears, rh toggles, block index rblk advances.
  - rblk wraps at osize-1 to 0, and on wrap obcnt increments.
  - oacnt = rblk.
- Oen & ~Ovalid: no pointer movement; underrun<=1.
- Simultaneous events:
  - The fetch fill (hv[fh] set) and consumer release (hv[rh] clear) always hit different halves, so both take effect.
  - The same half cannot be set and cleared in one cycle, because a fetch only starts when hv[fh]==0.
- Latency:
  - First Ovalid at least 3 cycles + AXI latency after sync deassert.
  - Read of a filled half is zero-wait.
- sync=1:
  - Clears rcnt, rblk, obcnt, hv, fh, rh, fblk, underrun, rerr.
  - In AR: arvalid stays asserted until the handshake (no AXI violation).
  - In AR or R: drop<=1, so remaining beats are accepted with a2s_en=0 and the FSM returns to IDLE.
  - sync has priority over Oen in the same cycle.
- osize change mid-run is undefined; software asserts sync after changing it.

Decomposition:
- Shared package a2s_pkg holds:
  - FSM state encoding (IDLE=2'd0, AR=2'd1, R=2'd2).
  - BURST_BEATS and ARLEN constants.
  - Block address width constants (6-bit offset, 18-bit block index).
- One sub-module is natural: a2s_ring_ptr (block index + wrap counter, parameterised on width).
  - Instantiated twice: once for fetch (fblk) and once for consumer (rblk/obcnt).

Test Plan:
- Reset then sync pulse, obase=0x1000_0000, osize=4, arready/rvalid always 1:
  - Bursts issue at 0x1000_0000, 0x1000_0040.
  - a2s_addr runs 0..15 then 16..31.
  - Ovalid=1 after the first rlast.
  - No third AR until the consumer frees half 0.
- Continuous Oen for 4*16*3 words with osize=4:
  - Araddr sequence wraps 0x..C0 -> 0x..00.
  - obcnt=2 after 128 words, oacnt back to 0, underrun stays 0.
- Oen held from sync with 10-cycle AR latency:
  - underrun=1; Oaddr stays 0 until hv[0] is set.
- sync asserted mid-R at beat 7:
  - Beats 8..15 have a2s_en=0.
  - hv=00 afterwards.
  - Next AR address is obase+0.
- Beat 5 with rresp=2'b10 -> rerr=1.
  - Data is still written; the FSM completes normally.
- arready low for 20 cycles:
  - arvalid and araddr stable throughout; exactly one handshake.
